// File: rtl/ysyx_22050710_lsu_sram_master.sv
// ysyx_22050710_lsu_sram_master: LSU load/store initiator for the 1-cycle registered data SRAM.
// Latency: store response 1 cycle after accept, load response 2 cycles after accept.
// Backpressure: one request in flight; o_req_ready only in IDLE, response held until i_resp_ready.
//
// Ports:
//   i_clk / i_rst            clock, synchronous active-high reset
//   i_req_*  / o_req_ready   request channel (wen, RV funct3, byte address, LSB-aligned store data)
//   o_resp_* / i_resp_ready  response channel (extended load data, misalign flag)
//   o_sram_* / i_sram_rdata  single-port SRAM interface (doubleword address, byte mask)
//
// Optional feature macro: LSU_MISALIGN_TRAP_EN
//   defined   : misaligned requests skip the SRAM and respond with o_resp_misalign=1, rdata=0
//   undefined : misaligned requests go to the SRAM with lanes past byte 7 dropped; flag tied 0
module ysyx_22050710_lsu_sram_master #(
  parameter int ADDR_WD  = 32,
  parameter int DATA_WD  = 64,
  parameter int WMASK_WD = 8
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_req_valid,
  output logic                o_req_ready,
  input  logic                i_req_wen,
  input  logic [2:0]          i_req_func,
  input  logic [ADDR_WD-1:0]  i_req_addr,
  input  logic [DATA_WD-1:0]  i_req_wdata,
  output logic                o_resp_valid,
  input  logic                i_resp_ready,
  output logic [DATA_WD-1:0]  o_resp_rdata,
  output logic                o_resp_misalign,
  output logic [ADDR_WD-1:0]  o_sram_addr,
  output logic                o_sram_ren,
  output logic                o_sram_wen,
  output logic [WMASK_WD-1:0] o_sram_wmask,
  output logic [DATA_WD-1:0]  o_sram_wdata,
  input  logic [DATA_WD-1:0]  i_sram_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_RDATA, S_RESP} state_e;

  state_e              state_q, state_d;
  logic [2:0]          off_q;
  logic [2:0]          func_q;
  logic [DATA_WD-1:0]  rdata_q;

  logic [2:0]          req_off;
  logic [1:0]          req_sz;
  logic [WMASK_WD-1:0] mask_base;
  logic                req_acc;
  logic                sram_go;
  logic [DATA_WD-1:0]  ld_shift;
  logic [DATA_WD-1:0]  ld_ext;

  assign req_off = i_req_addr[2:0];
  assign req_sz  = i_req_func[1:0];
  assign req_acc = i_req_valid & o_req_ready;

  // Byte-lane mask of the access before lane shifting; func=111 falls into the D case.
  always_comb begin
    mask_base = '0;
    case (req_sz)
      2'd0:    mask_base = 8'h01;
      2'd1:    mask_base = 8'h03;
      2'd2:    mask_base = 8'h0F;
      default: mask_base = 8'hFF;
    endcase
  end

`ifdef LSU_MISALIGN_TRAP_EN
  logic req_mis;
  logic mis_q;

  // Natural alignment check; for power-of-two sizes this also covers (off+n)>8.
  always_comb begin
    req_mis = 1'b0;
    case (req_sz)
      2'd1:    req_mis = req_off[0];
      2'd2:    req_mis = |req_off[1:0];
      2'd3:    req_mis = |req_off;
      default: req_mis = 1'b0;
    endcase
  end

  assign sram_go = (state_q == S_IDLE) & i_req_valid & ~i_rst & ~req_mis;
`else
  assign sram_go = (state_q == S_IDLE) & i_req_valid & ~i_rst;
`endif

  // SRAM side is combinational from the request; the 8-bit shift drops lanes past byte 7.
  assign o_sram_addr  = {i_req_addr[ADDR_WD-1:3], 3'b000};
  assign o_sram_ren   = sram_go & ~i_req_wen;
  assign o_sram_wen   = sram_go & i_req_wen;
  assign o_sram_wmask = sram_go ? (mask_base << req_off) : '0;
  assign o_sram_wdata = i_req_wdata << {req_off, 3'b000};

  // Load alignment: zeros shift in from the top, so truncated misaligned bytes read as 0.
  assign ld_shift = i_sram_rdata >> {off_q, 3'b000};

  always_comb begin
    ld_ext = ld_shift;
    case (func_q)
      3'b000:  ld_ext = {{(DATA_WD-8){ld_shift[7]}},   ld_shift[7:0]};
      3'b001:  ld_ext = {{(DATA_WD-16){ld_shift[15]}}, ld_shift[15:0]};
      3'b010:  ld_ext = {{(DATA_WD-32){ld_shift[31]}}, ld_shift[31:0]};
      3'b100:  ld_ext = {{(DATA_WD-8){1'b0}},          ld_shift[7:0]};
      3'b101:  ld_ext = {{(DATA_WD-16){1'b0}},         ld_shift[15:0]};
      3'b110:  ld_ext = {{(DATA_WD-32){1'b0}},         ld_shift[31:0]};
      default: ld_ext = ld_shift;
    endcase
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (req_acc) begin
`ifdef LSU_MISALIGN_TRAP_EN
          if (i_req_wen || req_mis) state_d = S_RESP;
          else                      state_d = S_RDATA;
`else
          if (i_req_wen) state_d = S_RESP;
          else           state_d = S_RDATA;
`endif
        end
      end
      S_RDATA: state_d = S_RESP;
      S_RESP:  if (i_resp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs.
  always_comb begin
    o_req_ready  = (state_q == S_IDLE);
    o_resp_valid = (state_q == S_RESP);
    o_resp_rdata = rdata_q;
  end

  // Request fields captured at accept; response data cleared at accept so stores/traps return 0.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      off_q   <= '0;
      func_q  <= '0;
      rdata_q <= '0;
    end else begin
      if (req_acc) begin
        off_q   <= req_off;
        func_q  <= i_req_func;
        rdata_q <= '0;
      end else if (state_q == S_RDATA) begin
        rdata_q <= ld_ext;
      end
    end
  end

`ifdef LSU_MISALIGN_TRAP_EN
  always_ff @(posedge i_clk) begin
    if (i_rst)        mis_q <= 1'b0;
    else if (req_acc) mis_q <= req_mis;
  end

  assign o_resp_misalign = mis_q;
`else
  assign o_resp_misalign = 1'b0;
`endif

endmodule

// File: tb/tb_ysyx_22050710_lsu_sram_master.sv
// Testbench for ysyx_22050710_lsu_sram_master with a small byte-masked SRAM model.
// Latency: checks 1-cycle store and 2-cycle load response timing against accept.
// Backpressure: holds i_resp_ready low to check response stability and o_req_ready=0.
module tb_ysyx_22050710_lsu_sram_master;

  logic        clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_req_valid = 1'b0;
  logic        o_req_ready;
  logic        i_req_wen = 1'b0;
  logic [2:0]  i_req_func = 3'b000;
  logic [31:0] i_req_addr = 32'h0;
  logic [63:0] i_req_wdata = 64'h0;
  logic        o_resp_valid;
  logic        i_resp_ready = 1'b1;
  logic [63:0] o_resp_rdata;
  logic        o_resp_misalign;
  logic [31:0] o_sram_addr;
  logic        o_sram_ren;
  logic        o_sram_wen;
  logic [7:0]  o_sram_wmask;
  logic [63:0] o_sram_wdata;
  logic [63:0] i_sram_rdata = 64'h0;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  logic mem_clr = 1'b1;
  logic [63:0] mem [16];

  typedef struct {
    logic [63:0] rdata;
    logic        mis;
    int          acc;
    int          lat;
  } exp_t;
  exp_t sb[$];
  exp_t cur;
  logic seen = 1'b0;

  ysyx_22050710_lsu_sram_master dut (
    .i_clk(clk), .i_rst(i_rst),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_req_wen(i_req_wen), .i_req_func(i_req_func),
    .i_req_addr(i_req_addr), .i_req_wdata(i_req_wdata),
    .o_resp_valid(o_resp_valid), .i_resp_ready(i_resp_ready),
    .o_resp_rdata(o_resp_rdata), .o_resp_misalign(o_resp_misalign),
    .o_sram_addr(o_sram_addr), .o_sram_ren(o_sram_ren), .o_sram_wen(o_sram_wen),
    .o_sram_wmask(o_sram_wmask), .o_sram_wdata(o_sram_wdata),
    .i_sram_rdata(i_sram_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // SRAM model: write on posedge with byte mask, registered read.
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 16; i++) mem[i] <= 64'h0;
    end else begin
      if (o_sram_wen)
        for (int b = 0; b < 8; b++)
          if (o_sram_wmask[b]) mem[o_sram_addr[6:3]][8*b +: 8] <= o_sram_wdata[8*b +: 8];
      if (o_sram_ren) i_sram_rdata <= mem[o_sram_addr[6:3]];
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Response monitor: latency on the first valid cycle, data/flag on handshake.
  always @(negedge clk) begin
    if (o_resp_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_resp", {63'h0, o_resp_valid}, 64'h0);
      end else begin
        if (!seen) begin
          chk("resp_latency", 64'(cyc - sb[0].acc), 64'(sb[0].lat));
          seen = 1'b1;
        end
        if (i_resp_ready) begin
          cur = sb.pop_front();
          chk("resp_rdata", o_resp_rdata, cur.rdata);
          chk("resp_misalign", {63'h0, o_resp_misalign}, {63'h0, cur.mis});
          seen = 1'b0;
        end
      end
    end
  end

  task automatic issue(input logic wen, input logic [2:0] func, input logic [31:0] addr,
                       input logic [63:0] wd, input logic e_ren, input logic e_wen,
                       input logic [7:0] e_mask, input logic [63:0] e_wdata,
                       input logic [63:0] e_rdata, input logic e_mis, input int e_lat);
    exp_t e;
    @(posedge clk); #2;
    i_req_valid = 1'b1; i_req_wen = wen; i_req_func = func;
    i_req_addr = addr; i_req_wdata = wd;
    @(negedge clk);
    chk("req_ready", {63'h0, o_req_ready}, 64'h1);
    chk("sram_ren", {63'h0, o_sram_ren}, {63'h0, e_ren});
    chk("sram_wen", {63'h0, o_sram_wen}, {63'h0, e_wen});
    chk("sram_wmask", {56'h0, o_sram_wmask}, {56'h0, e_mask});
    chk("sram_addr", {32'h0, o_sram_addr}, {32'h0, addr[31:3], 3'b000});
    if (e_wen) chk("sram_wdata", o_sram_wdata, e_wdata);
    e.rdata = e_rdata; e.mis = e_mis; e.acc = cyc; e.lat = e_lat;
    sb.push_back(e);
    @(posedge clk); #2;
    i_req_valid = 1'b0; i_req_addr = 32'hDEAD_BEE0; i_req_func = 3'b000; i_req_wdata = '1;
  endtask

  task automatic wait_idle();
    logic done;
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (o_req_ready && sb.size() == 0) done = 1'b1;
    end
    if (!done) chk("idle_timeout", 64'h0, 64'h1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_resp_valid", {63'h0, o_resp_valid}, 64'h0);
    chk("rst_resp_rdata", o_resp_rdata, 64'h0);
    chk("rst_misalign", {63'h0, o_resp_misalign}, 64'h0);
    chk("rst_req_ready", {63'h0, o_req_ready}, 64'h1);
    @(posedge clk); #2; i_rst = 1'b0; mem_clr = 1'b0;

    // Store D, aligned.
    issue(1, 3'b011, 32'h8000_0008, 64'h1122334455667788, 0, 1, 8'hFF, 64'h1122334455667788, 64'h0, 0, 1);
    wait_idle();
    // Store B lane 3, then LB back with sign extension.
    issue(1, 3'b000, 32'h8000_0013, 64'h00000000000000AB, 0, 1, 8'h08, 64'h00000000AB000000, 64'h0, 0, 1);
    wait_idle();
    issue(0, 3'b000, 32'h8000_0013, 64'h0, 1, 0, 8'h08, 64'h0, 64'hFFFFFFFFFFFFFFAB, 0, 2);
    wait_idle();
    // Store H into lanes 2-3 of the first doubleword, then LD it back.
    issue(1, 3'b001, 32'h8000_000A, 64'h000000000000BEEF, 0, 1, 8'h0C, 64'h00000000BEEF0000, 64'h0, 0, 1);
    wait_idle();
    issue(0, 3'b011, 32'h8000_0008, 64'h0, 1, 0, 8'hFF, 64'h0, 64'h11223344BEEF7788, 0, 2);
    wait_idle();
    // Word 0x8000_1234_0000_0000, then loads of varying size/sign.
    issue(1, 3'b011, 32'h8000_0010, 64'h8000123400000000, 0, 1, 8'hFF, 64'h8000123400000000, 64'h0, 0, 1);
    wait_idle();
    issue(0, 3'b101, 32'h8000_0016, 64'h0, 1, 0, 8'hC0, 64'h0, 64'h0000000000008000, 0, 2);
    wait_idle();
    issue(0, 3'b010, 32'h8000_0014, 64'h0, 1, 0, 8'hF0, 64'h0, 64'hFFFFFFFF80001234, 0, 2);
    wait_idle();
    issue(0, 3'b110, 32'h8000_0014, 64'h0, 1, 0, 8'hF0, 64'h0, 64'h0000000080001234, 0, 2);
    wait_idle();
    issue(0, 3'b100, 32'h8000_0017, 64'h0, 1, 0, 8'h80, 64'h0, 64'h0000000000000080, 0, 2);
    wait_idle();
    issue(0, 3'b111, 32'h8000_0010, 64'h0, 1, 0, 8'hFF, 64'h0, 64'h8000123400000000, 0, 2);
    wait_idle();

    // Response backpressure: LH held for several cycles.
    @(posedge clk); #2; i_resp_ready = 1'b0;
    issue(0, 3'b001, 32'h8000_0016, 64'h0, 1, 0, 8'hC0, 64'h0, 64'hFFFFFFFFFFFF8000, 0, 2);
    for (int i = 0; i < 10 && !o_resp_valid; i++) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      chk("hold_valid", {63'h0, o_resp_valid}, 64'h1);
      chk("hold_rdata", o_resp_rdata, 64'hFFFFFFFFFFFF8000);
      chk("hold_req_ready", {63'h0, o_req_ready}, 64'h0);
    end
    @(posedge clk); #2; i_resp_ready = 1'b1;
    wait_idle();

    // Reset while in RDATA drops the response.
    @(posedge clk); #2;
    i_req_valid = 1'b1; i_req_wen = 1'b0; i_req_func = 3'b011; i_req_addr = 32'h8000_0010;
    @(posedge clk); #2;
    i_req_valid = 1'b0; i_rst = 1'b1;
    @(posedge clk); #2; i_rst = 1'b0;
    @(negedge clk);
    chk("rst_rdata_valid", {63'h0, o_resp_valid}, 64'h0);
    chk("rst_rdata_idle", {63'h0, o_req_ready}, 64'h1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rst_no_resp", {63'h0, o_resp_valid}, 64'h0);
    end
    // Store presented during reset must not write.
    @(posedge clk); #2;
    i_rst = 1'b1; i_req_valid = 1'b1; i_req_wen = 1'b1; i_req_func = 3'b011;
    i_req_addr = 32'h8000_0010; i_req_wdata = 64'h5555555555555555;
    @(negedge clk);
    chk("rst_store_wen", {63'h0, o_sram_wen}, 64'h0);
    chk("rst_store_ren", {63'h0, o_sram_ren}, 64'h0);
    @(posedge clk); #2; i_rst = 1'b0; i_req_valid = 1'b0;
    @(negedge clk);
    chk("rst_store_no_resp", {63'h0, o_resp_valid}, 64'h0);
    // Memory must still hold the earlier doubleword.
    issue(0, 3'b011, 32'h8000_0010, 64'h0, 1, 0, 8'hFF, 64'h0, 64'h8000123400000000, 0, 2);
    wait_idle();

    // Misaligned LW at offset 6.
    issue(1, 3'b011, 32'h8000_0000, 64'hCAFEBABEDEADBEEF, 0, 1, 8'hFF, 64'hCAFEBABEDEADBEEF, 64'h0, 0, 1);
    wait_idle();
`ifdef LSU_MISALIGN_TRAP_EN
    issue(0, 3'b010, 32'h8000_0006, 64'h0, 0, 0, 8'h00, 64'h0, 64'h0, 1, 1);
`else
    issue(0, 3'b010, 32'h8000_0006, 64'h0, 1, 0, 8'hC0, 64'h0, 64'h000000000000CAFE, 0, 2);
`endif
    wait_idle();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
